// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

    // Access size encodings; 2'b11 is handled as a byte access.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Wait-state counter width, enough for 0..15 wait states.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane merge for stores and right-justified lane extraction for loads.
// Latency: combinational.
// Backpressure: none.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] st_word,
    output logic [31:0] ld_val
);

    logic [4:0] byte_ofs;

    // Low address bits are forced to the natural alignment of the access.
    assign byte_ofs = {addr_lo, 3'b000};

    // Select the lanes touched by the access; untouched lanes keep old data.
    always_comb begin
        st_word = old_word;
        ld_val  = 32'h0;
        case (size)
            SZ_WORD: begin
                st_word = wdata;
                ld_val  = old_word;
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    st_word[31:16] = wdata[15:0];
                    ld_val         = {16'h0, old_word[31:16]};
                end else begin
                    st_word[15:0]  = wdata[15:0];
                    ld_val         = {16'h0, old_word[15:0]};
                end
            end
            default: begin
                st_word[byte_ofs +: 8] = wdata[7:0];
                ld_val                 = {24'h0, old_word[byte_ofs +: 8]};
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder; optional misalignment trap under DMEM_ALIGN_CHECK_EN.
// Latency: Done/ReadData registered WAIT_STATES+1 edges after the capture edge.
// Backpressure: Stall held with a pending request until the response cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             capture;
    logic             request;

    logic             op_wr;
    logic [1:0]       size_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      old_word;
    logic [31:0]      st_word;
    logic [31:0]      ld_val;
    logic             misaligned;
    logic             unused_addr_hi;

    // Upper address bits alias onto the array.
    assign unused_addr_hi = ^Address[31:IDX_W+2];

    assign request  = MemRead | MemWrite;
    assign Stall    = request & (state != RESP);
    assign idx      = addr_q[IDX_W+1:2];
    assign old_word = mem[idx];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                        ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    dmem_lane_align u_lane_align (
        .old_word (old_word),
        .wdata    (wdata_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .st_word  (st_word),
        .ld_val   (ld_val)
    );

    // State and wait-state counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next state: capture in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!request) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the request at capture; a write wins when both strobes are high.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_wr   <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            op_wr   <= MemWrite;
            size_q  <= Size;
            addr_q  <= Address[IDX_W+1:0];
            wdata_q <= WriteData;
        end
    end

    // Response registers; ReadData holds between completions.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ReadData <= '0;
            Done     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            Done <= (state == RESP);
            Err  <= (state == RESP) & misaligned;
            if (state == RESP) begin
                ReadData <= (op_wr || misaligned) ? 32'h0 : ld_val;
            end
        end
    end

    // Array update happens only on the RESP edge; contents survive reset.
    always_ff @(posedge Clk) begin
        if ((state == RESP) && op_wr && !misaligned) begin
            mem[idx] <= st_word;
        end
    end

endmodule
